lane_dmem_banked: RTL and testbench

LANE_DMEM_BANKED -- requirements
Module: lane_dmem_banked

---
 rtl/lane_dmem_banked.sv | 213 +++++++++++++++++++++
 tb/tb_lane_dmem_banked.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_dmem_banked.sv
// Purpose : warp-wide banked data memory; per cycle each word-interleaved bank serves its lowest pending lane.
// Latency : S service cycles (S = worst per-bank lane count, min 1), then LATENCY-1 wait cycles, then a one-cycle RESP.
// Backpressure: dmem_ready only in IDLE/RESP; requests seen while not ready are dropped, there is no queue.
// Ports   : clk/rst_n (sync active-low); dmem_req + lane_valid/addr/wdata/we/size request bundle; dmem_ready;
//           dmem_resp_valid pulse with dmem_rdata/dmem_lane_resp_valid; svc_cycles and conflict_cnt statistics.

package lane_dmem_pkg;
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;
endpackage

module lane_dmem_banked
    import lane_dmem_pkg::*;
#(
    parameter int WARP_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BANKS  = 8,
    parameter int MEM_BYTES  = 65536,
    parameter int LATENCY    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  dmem_req,
    input  logic [WARP_SIZE-1:0]                  dmem_lane_valid,
    input  logic [WARP_SIZE-1:0][ADDR_WIDTH-1:0]  dmem_addr,
    input  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  dmem_wdata,
    input  logic                                  dmem_we,
    input  mem_size_t                             dmem_size,
    output logic                                  dmem_ready,
    output logic                                  dmem_resp_valid,
    output logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  dmem_rdata,
    output logic [WARP_SIZE-1:0]                  dmem_lane_resp_valid,
    output logic [$clog2(WARP_SIZE):0]            svc_cycles,
    output logic [31:0]                           conflict_cnt
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int MA        = $clog2(MEM_BYTES);
    localparam int CW        = $clog2(WARP_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, SERVICE, WAIT, RESP} state_t;

    state_t                               state;
    logic [WARP_SIZE-1:0]                 lane_valid_q;
    logic [WARP_SIZE-1:0]                 pending;
    logic [WARP_SIZE-1:0]                 sel;
    logic [WARP_SIZE-1:0][MA-1:0]         addr_q;
    logic [WARP_SIZE-1:0][31:0]           wdata_q;
    logic                                 we_q;
    mem_size_t                            size_q;
    logic [CW-1:0]                        svc_cnt;
    logic [2:0]                           wait_cnt;
    logic [7:0]                           mem [MEM_BYTES];
    logic [WARP_SIZE-1:0][BANK_BITS-1:0]  lane_bank;
    logic [NUM_BANKS-1:0]                 bank_taken;
    logic [WARP_SIZE-1:0][31:0]           rd_word;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] rbuf;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] rbuf_nxt;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] resp_data;
    logic [WARP_SIZE-1:0]                 left_after;
    logic [32:0]                          conf_sum;
    logic                                 accept;
    logic                                 unused_in_bits;

    // Only the low MA address bits and low 32 data bits matter.
    assign unused_in_bits = ^{dmem_addr, dmem_wdata};

    assign accept     = dmem_req && dmem_ready;
    assign left_after = pending & ~sel;
    // svc_cnt equals S-1 on the last service cycle, i.e. the extra cycles.
    assign conf_sum   = {1'b0, conflict_cnt} + 33'(svc_cnt);

    // Lane to bank: word-interleaved on address bits [2 +: log2(NUM_BANKS)].
    always_comb begin
        for (int l = 0; l < WARP_SIZE; l++) begin
            lane_bank[l] = BANK_BITS'((addr_q[l] >> 2) & MA'(NUM_BANKS - 1));
        end
    end

    // Per bank, pick the lowest-index pending lane.
    always_comb begin
        bank_taken = '0;
        sel        = '0;
        for (int l = 0; l < WARP_SIZE; l++) begin
            if (pending[l] && !bank_taken[lane_bank[l]]) begin
                sel[l]                   = 1'b1;
                bank_taken[lane_bank[l]] = 1'b1;
            end
        end
    end

    // Little-endian read with per-byte wrap, zero-extended by access size.
    always_comb begin
        for (int l = 0; l < WARP_SIZE; l++) begin
            rd_word[l] = {mem[addr_q[l] + MA'(3)], mem[addr_q[l] + MA'(2)],
                          mem[addr_q[l] + MA'(1)], mem[addr_q[l]]};
            if (size_q == MEM_BYTE) begin
                rd_word[l][31:8] = '0;
            end else if (size_q == MEM_HALF) begin
                rd_word[l][31:16] = '0;
            end
        end
    end

    // rbuf_nxt folds in the current cycle's reads so a LATENCY=1 response
    // straight out of the last service cycle still sees them.
    always_comb begin
        for (int l = 0; l < WARP_SIZE; l++) begin
            rbuf_nxt[l]  = sel[l] ? DATA_WIDTH'(rd_word[l]) : rbuf[l];
            resp_data[l] = (lane_valid_q[l] && !we_q) ? rbuf_nxt[l] : '0;
        end
    end

    // Storage, captured request and load buffer are not reset. The storage
    // port ignores rst_n so an access issued on the reset edge still lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_valid_q <= dmem_lane_valid;
            we_q         <= dmem_we;
            size_q       <= dmem_size;
            for (int l = 0; l < WARP_SIZE; l++) begin
                addr_q[l]  <= dmem_addr[l][MA-1:0];
                wdata_q[l] <= 32'(dmem_wdata[l]);
            end
        end
        if (state == SERVICE && we_q) begin
            // Ascending lane order: on overlapping bytes the higher lane wins.
            for (int l = 0; l < WARP_SIZE; l++) begin
                if (sel[l]) begin
                    mem[addr_q[l]] <= wdata_q[l][7:0];
                    if (size_q != MEM_BYTE) begin
                        mem[addr_q[l] + MA'(1)] <= wdata_q[l][15:8];
                    end
                    if (size_q != MEM_BYTE && size_q != MEM_HALF) begin
                        mem[addr_q[l] + MA'(2)] <= wdata_q[l][23:16];
                        mem[addr_q[l] + MA'(3)] <= wdata_q[l][31:24];
                    end
                end
            end
        end
        if (state == SERVICE && !we_q) begin
            rbuf <= rbuf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            dmem_ready           <= 1'b1;
            dmem_resp_valid      <= 1'b0;
            dmem_rdata           <= '0;
            dmem_lane_resp_valid <= '0;
            svc_cycles           <= '0;
            conflict_cnt         <= '0;
            pending              <= '0;
            svc_cnt              <= '0;
            wait_cnt             <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    dmem_resp_valid <= 1'b0;
                    if (dmem_req) begin
                        pending    <= dmem_lane_valid;
                        svc_cnt    <= '0;
                        state      <= SERVICE;
                        dmem_ready <= 1'b0;
                    end else begin
                        state      <= IDLE;
                        dmem_ready <= 1'b1;
                    end
                end
                SERVICE: begin
                    pending <= left_after;
                    svc_cnt <= svc_cnt + CW'(1);
                    if (left_after == '0) begin
                        svc_cycles   <= svc_cnt + CW'(1);
                        conflict_cnt <= conf_sum[32] ? 32'hFFFF_FFFF : conf_sum[31:0];
                        if (LATENCY > 1) begin
                            state    <= WAIT;
                            wait_cnt <= 3'(LATENCY - 2);
                        end else begin
                            state                <= RESP;
                            dmem_ready           <= 1'b1;
                            dmem_resp_valid      <= 1'b1;
                            dmem_lane_resp_valid <= lane_valid_q;
                            dmem_rdata           <= resp_data;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state                <= RESP;
                        dmem_ready           <= 1'b1;
                        dmem_resp_valid      <= 1'b1;
                        dmem_lane_resp_valid <= lane_valid_q;
                        dmem_rdata           <= resp_data;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    dmem_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_dmem_banked.sv
// Purpose : directed checks of lane_dmem_banked with default parameters.
// Latency : responses are expected S+2 cycles after the accept edge (LATENCY=2).
// Backpressure: requests are issued only when dmem_ready is high, except where dropping is being probed.

module tb_lane_dmem_banked;
    import lane_dmem_pkg::*;

    localparam int W  = 32;
    localparam int DW = 32;
    localparam int AW = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   dmem_req;
    logic [W-1:0]           dmem_lane_valid;
    logic [W-1:0][AW-1:0]   dmem_addr;
    logic [W-1:0][DW-1:0]   dmem_wdata;
    logic                   dmem_we;
    mem_size_t              dmem_size;
    logic                   dmem_ready;
    logic                   dmem_resp_valid;
    logic [W-1:0][DW-1:0]   dmem_rdata;
    logic [W-1:0]           dmem_lane_resp_valid;
    logic [$clog2(W):0]     svc_cycles;
    logic [31:0]            conflict_cnt;

    always #5 clk = ~clk;

    lane_dmem_banked dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .dmem_req             (dmem_req),
        .dmem_lane_valid      (dmem_lane_valid),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_we              (dmem_we),
        .dmem_size            (dmem_size),
        .dmem_ready           (dmem_ready),
        .dmem_resp_valid      (dmem_resp_valid),
        .dmem_rdata           (dmem_rdata),
        .dmem_lane_resp_valid (dmem_lane_resp_valid),
        .svc_cycles           (svc_cycles),
        .conflict_cnt         (conflict_cnt)
    );

    // Lane i: addr = base + stride*i, wdata = wbase + wstep*i;
    // expected load data on active lanes = rbase + rstep*i.
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] lv;
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] wbase;
        logic [31:0] wstep;
        int          exp_svc;
        logic [31:0] rbase;
        logic [31:0] rstep;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_conf = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0][DW-1:0] exp_rd(input vec_t v);
        logic [W-1:0][DW-1:0] r;
        for (int l = 0; l < W; l++) begin
            r[l] = (!v.we && v.lv[l]) ? v.rbase + v.rstep * 32'(l) : 32'd0;
        end
        return r;
    endfunction

    task automatic chk_rdata(input string nm, input logic [W-1:0][DW-1:0] exp);
        int bad = -1;
        for (int l = 0; l < W; l++) begin
            if (dmem_rdata[l] !== exp[l] && bad < 0) bad = l;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: lane %0d got 0x%0h expected 0x%0h", nm, bad, dmem_rdata[bad], exp[bad]);
        end
    endtask

    task automatic drive(input vec_t v);
        dmem_we         = v.we;
        dmem_size       = mem_size_t'(v.size);
        dmem_lane_valid = v.lv;
        for (int l = 0; l < W; l++) begin
            dmem_addr[l]  = v.base + v.stride * 32'(l);
            dmem_wdata[l] = v.wbase + v.wstep * 32'(l);
        end
    endtask

    // Counts negedges after the accept edge until resp_valid; bounded.
    task automatic wait_resp(output int n);
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (dmem_resp_valid === 1'b1) break;
        end
    endtask

    task automatic check_resp(input string nm, input vec_t v);
        chk({nm, "_lane_resp"}, dmem_lane_resp_valid, v.lv);
        chk_rdata({nm, "_rdata"}, exp_rd(v));
        chk({nm, "_svc"}, svc_cycles, v.exp_svc);
        exp_conf = exp_conf + 32'(v.exp_svc - 1);
        chk({nm, "_conf"}, conflict_cnt, exp_conf);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int n;
        chk({nm, "_ready"}, dmem_ready, 1);
        drive(v);
        dmem_req = 1'b1;
        @(posedge clk);
        #1 dmem_req = 1'b0;
        wait_resp(n);
        chk({nm, "_lat"}, n, v.exp_svc + 2);
        check_resp(nm, v);
        @(negedge clk);
        chk({nm, "_pulse"}, dmem_resp_valid, 0);
        chk_rdata({nm, "_hold"}, exp_rd(v));
    endtask

    vec_t vt[16];

    initial begin
        int   n;
        int   pulses;
        vec_t va, vb, vr, vl;

        // we, size, lv, base, stride, wbase, wstep, exp_svc, rbase, rstep
        vt[0]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h1000, 32'd4,  32'd0,       32'd1, 4,  32'd0,       32'd0};
        vt[1]  = '{1'b0, 2'd2, 32'hFFFF_FFFF, 32'h1000, 32'd4,  32'd0,       32'd0, 4,  32'd0,       32'd1};
        vt[2]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0100, 32'd0,  32'd0,       32'd1, 32, 32'd0,       32'd0};
        vt[3]  = '{1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0100, 32'd0,  32'd0,       32'd0, 32, 32'd31,      32'd0};
        vt[4]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h2000, 32'd32, 32'hA000,    32'd1, 32, 32'd0,       32'd0};
        vt[5]  = '{1'b0, 2'd2, 32'hFFFF_FFFF, 32'h2000, 32'd32, 32'd0,       32'd0, 32, 32'hA000,    32'd1};
        vt[6]  = '{1'b0, 2'd2, 32'h0000_00FF, 32'h1000, 32'd4,  32'd0,       32'd0, 1,  32'd0,       32'd1};
        vt[7]  = '{1'b1, 2'd2, 32'h0000_0001, 32'h0200, 32'd0,  32'd0,       32'd0, 1,  32'd0,       32'd0};
        vt[8]  = '{1'b1, 2'd0, 32'h0000_0001, 32'h0203, 32'd0,  32'h123456AB, 32'd0, 1, 32'd0,       32'd0};
        vt[9]  = '{1'b0, 2'd2, 32'h0000_0001, 32'h0200, 32'd0,  32'd0,       32'd0, 1,  32'hAB000000, 32'd0};
        vt[10] = '{1'b0, 2'd1, 32'h0000_0001, 32'h0202, 32'd0,  32'd0,       32'd0, 1,  32'h0000AB00, 32'd0};
        vt[11] = '{1'b0, 2'd0, 32'h0000_0001, 32'h0203, 32'd0,  32'd0,       32'd0, 1,  32'h000000AB, 32'd0};
        vt[12] = '{1'b1, 2'd2, 32'h0000_0001, 32'hFFFE, 32'd0,  32'h44332211, 32'd0, 1, 32'd0,       32'd0};
        vt[13] = '{1'b0, 2'd0, 32'h0000_000F, 32'hFFFE, 32'd1,  32'd0,       32'd0, 2,  32'h11,      32'h11};
        vt[14] = '{1'b0, 2'd1, 32'h0000_0001, 32'hFFFF, 32'd0,  32'd0,       32'd0, 1,  32'h3322,    32'd0};
        vt[15] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000, 32'd0,  32'd0,       32'd0, 1,  32'd0,       32'd0};

        rst_n    = 1'b0;
        dmem_req = 1'b0;
        drive(vt[15]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", dmem_ready, 1);
        chk("rst_resp_valid", dmem_resp_valid, 0);
        chk("rst_rdata_or", |dmem_rdata, 0);
        chk("rst_lane_resp", dmem_lane_resp_valid, 0);
        chk("rst_svc", svc_cycles, 0);
        chk("rst_conf", conflict_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_vec($sformatf("v%0d", i), vt[i]);
        end

        // Request B is presented while A is in service (must be ignored),
        // then held through A's RESP cycle where it must be taken directly.
        va = vt[1];
        vb = vt[9];
        chk("b2b_ready", dmem_ready, 1);
        drive(va);
        dmem_req = 1'b1;
        @(posedge clk);
        #1 drive(vb);
        wait_resp(n);
        chk("b2b_a_lat", n, 6);
        check_resp("b2b_a", va);
        @(negedge clk);
        chk("b2b_no_gap_ready", dmem_ready, 0);
        chk("b2b_no_gap_resp", dmem_resp_valid, 0);
        dmem_req = 1'b0;
        wait_resp(n);
        chk("b2b_b_lat", n + 1, 3);
        check_resp("b2b_b", vb);
        @(negedge clk);
        chk("b2b_b_pulse", dmem_resp_valid, 0);

        // Reset during the third service cycle of a same-address store.
        vr = vt[2];
        drive(vr);
        dmem_req = 1'b1;
        @(posedge clk);
        #1 dmem_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", dmem_ready, 1);
        chk("mid_rst_resp", dmem_resp_valid, 0);
        chk("mid_rst_conf", conflict_cnt, 0);
        chk("mid_rst_svc", svc_cycles, 0);
        chk("mid_rst_rdata_or", |dmem_rdata, 0);
        rst_n    = 1'b1;
        exp_conf = 32'd0;
        pulses   = 0;
        repeat (40) begin
            @(negedge clk);
            if (dmem_resp_valid === 1'b1) pulses++;
        end
        chk("mid_rst_no_resp", pulses, 0);
        vl = vt[3];
        vl.rbase = 32'd2;
        run_vec("mid_rst_load", vl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
